seq_alu: RTL

//  Parametrised multicycle ALU. Single-cycle ops: shift, add/sub, logic, compare.

---
 rtl/seq_alu.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Multicycle ALU: single-cycle shift/arith/logic/compare, shift-add MULTU, restoring DIVU.
// Define ALU_DIVIDE_EN to build the divider; otherwise opcode 11 is treated as illegal.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             dz,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state, state_next;
  logic [SHW:0]     cnt;
  logic [WIDTH-1:0] work_hi, work_lo, opnd_b;
  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] sc_out, sc_hi;
  logic             sc_v, sc_dz, sc_ill, go_iter;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi, step_lo;
`ifdef ALU_DIVIDE_EN
  logic             iter_div;
  logic [WIDTH:0]   div_shift, div_diff;
`endif

  assign sum  = a + b;
  assign diff = a - b;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    sc_out  = '0;
    sc_hi   = '0;
    sc_v    = 1'b0;
    sc_dz   = 1'b0;
    sc_ill  = 1'b0;
    go_iter = 1'b0;
    case (aluop)
      4'd0: sc_out = a << b[SHW-1:0];
      4'd1: sc_out = a >> b[SHW-1:0];
      4'd2: begin
        sc_out = sum;
        sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd3: begin
        sc_out = diff;
        sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'd4: sc_out = a & b;
      4'd5: sc_out = a | b;
      4'd6: sc_out = a ^ b;
      4'd7: sc_out = ~(a | b);
      4'd8: sc_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd9: sc_out = {{(WIDTH-1){1'b0}}, (a < b)};
      4'd10: go_iter = 1'b1;
`ifdef ALU_DIVIDE_EN
      4'd11: begin
        if (b == '0) begin
          sc_out = '1;
          sc_hi  = a;
          sc_dz  = 1'b1;
        end else begin
          go_iter = 1'b1;
        end
      end
`endif
      default: sc_ill = 1'b1;
    endcase
  end

  // One iteration step; work_hi/work_lo hold {product} for MULTU, {remainder, quotient} for DIVU
  always_comb begin
    mul_sum = {1'b0, work_hi} + {1'b0, opnd_b};
    step_hi = work_lo[0] ? mul_sum[WIDTH:1] : {1'b0, work_hi[WIDTH-1:1]};
    step_lo = {(work_lo[0] ? mul_sum[0] : work_hi[0]), work_lo[WIDTH-1:1]};
`ifdef ALU_DIVIDE_EN
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_b};
    if (iter_div) begin
      step_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo = {work_lo[WIDTH-2:0], ~div_diff[WIDTH]};
    end
`endif
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = go_iter ? ITER : DONE;
      ITER:    if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Visible results change only on the edge that enters DONE
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt     <= '0;
      work_hi <= '0;
      work_lo <= '0;
      opnd_b  <= '0;
      out     <= '0;
      hi      <= '0;
      Z       <= 1'b0;
      N       <= 1'b0;
      V       <= 1'b0;
      dz      <= 1'b0;
      illegal <= 1'b0;
`ifdef ALU_DIVIDE_EN
      iter_div <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt     <= '0;
            work_hi <= '0;
            work_lo <= a;
            opnd_b  <= b;
`ifdef ALU_DIVIDE_EN
            iter_div <= (aluop == 4'd11);
`endif
            if (!go_iter) begin
              out     <= sc_out;
              hi      <= sc_hi;
              Z       <= (sc_out == '0) && !sc_ill;
              N       <= sc_out[WIDTH-1];
              V       <= sc_v;
              dz      <= sc_dz;
              illegal <= sc_ill;
            end
          end
        end
        ITER: begin
          cnt     <= cnt + (SHW+1)'(1);
          work_hi <= step_hi;
          work_lo <= step_lo;
          if (cnt == LAST) begin
            out     <= step_lo;
            hi      <= step_hi;
            Z       <= (step_lo == '0);
            N       <= step_lo[WIDTH-1];
            V       <= 1'b0;
            dz      <= 1'b0;
            illegal <= 1'b0;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
